lw_hazard_detector: RTL and testbench

- Detects load-use hazards in the 5-stage MIPS pipeline and produces the isLWHazard request consumed by the ID/EX bubble inserter.
- Produces the IF and IF/ID stall/flush controls.
- Tracks the load that has entered EX and runs a stop/drain state machine that quiesces the pipeline on a stop instruction.
- Sits beside the decoder in ID. Its inputs are the pre-bubble (_tmp) decode controls.

---
 rtl/lw_hazard_detector.sv | 106 ++++++++++
 tb/tb_lw_hazard_detector.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/lw_hazard_detector.sv
// Load-use hazard detector for the 5-stage MIPS pipeline, plus the stop/drain
// sequencer that quiesces the pipe when a stop instruction reaches ID.
module lw_hazard_detector #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWriteD_tmp,
    input  logic             MemtoRegD_tmp,
    input  logic             StopD_tmp,
    input  logic [4:0]       rwD_tmp,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             useRsD,
    input  logic             useRtD,
    output logic             isLWHazard,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    state_t     state;
    logic       ldE_valid;
    logic [4:0] ldE_rw;
    logic [2:0] drain_cnt;
    logic       ld_next;

    always_comb begin
        isLWHazard = (state != HALTED) && ldE_valid &&
                     ((useRsD && (rsD == ldE_rw)) || (useRtD && (rtD == ldE_rw)));
    end

    // A bubbled slot (hazard this cycle) must not re-arm the tracker, so each
    // hazard costs exactly one stall; MEM/WB forwarding covers the rest.
    assign ld_next = (state == RUN) && !isLWHazard && RegWriteD_tmp &&
                     MemtoRegD_tmp && (rwD_tmp != 5'd0);

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        FlushD = 1'b0;
        halted = 1'b0;
        case (state)
            RUN: begin
                StallF = isLWHazard;
                StallD = isLWHazard;
            end
            DRAIN: begin
                StallF = 1'b1;
                FlushD = 1'b1;
            end
            HALTED: begin
                StallF = 1'b1;
                StallD = 1'b1;
                halted = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ldE_valid <= 1'b0;
            ldE_rw    <= 5'd0;
        end else begin
            ldE_valid <= ld_next;
            ldE_rw    <= ld_next ? rwD_tmp : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            drain_cnt <= 3'd0;
        end else begin
            case (state)
                RUN: begin
                    // A concurrent hazard takes priority; the stop is retried once it clears.
                    if (StopD_tmp && !isLWHazard) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 3'd0) state <= HALTED;
                    else                   drain_cnt <= drain_cnt - 3'd1;
                end
                HALTED: ;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                 stall_count <= '0;
        else if (isLWHazard && (stall_count != '1)) stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_lw_hazard_detector.sv
// Scoreboard bench for lw_hazard_detector: driver pushes model expectations,
// a negedge monitor pops and compares against two DUTs (CNT_W=16 and CNT_W=2).
module tb_lw_hazard_detector;

    localparam int DRAIN = 3;

    logic clk, reset;
    logic wr, ld, stp, urs, urt;
    logic [4:0] rwd, rs, rt;

    logic haz, sf, sd, fd, hlt;
    logic [15:0] cnt;
    logic haz2, sf2, sd2, fd2, hlt2;
    logic [1:0] cnt2;

    lw_hazard_detector #(.DRAIN_CYCLES(DRAIN), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .RegWriteD_tmp(wr), .MemtoRegD_tmp(ld),
        .StopD_tmp(stp), .rwD_tmp(rwd), .rsD(rs), .rtD(rt), .useRsD(urs),
        .useRtD(urt), .isLWHazard(haz), .StallF(sf), .StallD(sd), .FlushD(fd),
        .halted(hlt), .stall_count(cnt));

    lw_hazard_detector #(.DRAIN_CYCLES(DRAIN), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .RegWriteD_tmp(wr), .MemtoRegD_tmp(ld),
        .StopD_tmp(stp), .rwD_tmp(rwd), .rsD(rs), .rtD(rt), .useRsD(urs),
        .useRtD(urt), .isLWHazard(haz2), .StallF(sf2), .StallD(sd2), .FlushD(fd2),
        .halted(hlt2), .stall_count(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        haz, sf, sd, fd, hlt;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference model: pending load register (-1 = none), the cycle the stop
    // was accepted, and plain integer counters.
    int pend_rw;
    bit accepted;
    int acc_cyc, cyc, mcnt, mcnt2;
    int cur_mode;          // 0 run, 1 drain, 2 halted
    bit cur_haz;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mode_now();
        if (!accepted) return 0;
        if (cyc - acc_cyc <= DRAIN) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        pend_rw = -1; accepted = 0; acc_cyc = 0; cyc = 0;
        mcnt = 0; mcnt2 = 0; cur_mode = 0; cur_haz = 0;
    endtask

    // Advance the model across a rising edge using the inputs held this cycle.
    task automatic model_step();
        if (cur_haz) begin
            if (mcnt < 65535) mcnt++;
            if (mcnt2 < 3) mcnt2++;
        end
        if (cur_mode == 0 && !cur_haz && wr && ld && rwd != 0) pend_rw = int'(rwd);
        else pend_rw = -1;
        if (cur_mode == 0 && stp && !cur_haz) begin
            accepted = 1;
            acc_cyc  = cyc;
        end
        cyc++;
    endtask

    task automatic push_exp();
        exp_t e;
        cur_mode = mode_now();
        cur_haz  = (cur_mode != 2) && (pend_rw > 0) &&
                   ((urs && int'(rs) == pend_rw) || (urt && int'(rt) == pend_rw));
        e.haz  = cur_haz;
        e.sf   = (cur_mode == 0) ? cur_haz : 1'b1;
        e.sd   = (cur_mode == 0) ? cur_haz : (cur_mode == 2);
        e.fd   = (cur_mode == 1);
        e.hlt  = (cur_mode == 2);
        e.cnt  = 16'(mcnt);
        e.cnt2 = 2'(mcnt2);
        q.push_back(e);
    endtask

    task automatic drive(input logic w, input logic l, input logic s, input logic [4:0] d,
                         input logic [4:0] a, input logic [4:0] b, input logic ua, input logic ub);
        @(posedge clk);
        model_step();
        #1;
        wr = w; ld = l; stp = s; rwd = d; rs = a; rt = b; urs = ua; urt = ub;
        push_exp();
    endtask

    task automatic clear_inputs();
        wr = 0; ld = 0; stp = 0; rwd = 0; rs = 0; rt = 0; urs = 0; urt = 0;
    endtask

    // Assert reset away from any edge and check outputs clear immediately.
    task automatic do_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        clear_inputs();
        #1;
        chk("rst_haz",   {31'd0, haz}, 32'd0);
        chk("rst_stallf", {31'd0, sf}, 32'd0);
        chk("rst_stalld", {31'd0, sd}, 32'd0);
        chk("rst_flushd", {31'd0, fd}, 32'd0);
        chk("rst_halted", {31'd0, hlt}, 32'd0);
        chk("rst_count", {16'd0, cnt}, 32'd0);
        chk("rst_count2", {30'd0, cnt2}, 32'd0);
        model_reset();
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: every negedge with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("isLWHazard",  {31'd0, haz}, {31'd0, e.haz});
                chk("StallF",      {31'd0, sf},  {31'd0, e.sf});
                chk("StallD",      {31'd0, sd},  {31'd0, e.sd});
                chk("FlushD",      {31'd0, fd},  {31'd0, e.fd});
                chk("halted",      {31'd0, hlt}, {31'd0, e.hlt});
                chk("stall_count", {16'd0, cnt}, {16'd0, e.cnt});
                chk("stall_count_w2", {30'd0, cnt2}, {30'd0, e.cnt2});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int halt_run;
        clear_inputs();
        model_reset();
        reset = 1'b0;
        #3;
        chk("init_haz",    {31'd0, haz}, 32'd0);
        chk("init_halted", {31'd0, hlt}, 32'd0);
        chk("init_count",  {16'd0, cnt}, 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b1;

        // lw $8 then add using rs=8 (held once by the stall)
        drive(1, 1, 0, 8, 0, 0, 0, 0);
        drive(1, 0, 0, 3, 8, 0, 1, 0);
        drive(1, 0, 0, 3, 8, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        // lw $0 then rs=0 reader; lw $8 then rt=8 unused; lw $8 then rs9/rt10
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 4, 0, 0, 1, 1);
        drive(1, 1, 0, 8, 0, 0, 0, 0);
        drive(1, 0, 0, 4, 0, 8, 0, 0);
        drive(1, 1, 0, 8, 0, 0, 0, 0);
        drive(1, 0, 0, 4, 9, 10, 1, 1);
        // back-to-back loads: lw $8, lw $9 (rs=8), add rs=9
        drive(1, 1, 0, 8, 0, 0, 0, 0);
        drive(1, 1, 0, 9, 8, 0, 1, 0);
        drive(1, 1, 0, 9, 8, 0, 1, 0);
        drive(1, 0, 0, 5, 9, 0, 1, 0);
        drive(1, 0, 0, 5, 9, 0, 1, 0);
        // stop coincident with a load-use hazard, then drain and halt
        drive(1, 1, 0, 5, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 5, 0, 1, 0);
        drive(0, 0, 1, 0, 5, 0, 1, 0);
        for (int i = 0; i < 6; i++) drive(1, 1, 1, 7, 7, 7, 1, 1);
        do_reset();
        // stop without hazard, reset during the second drain cycle
        drive(0, 0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        // five hazards: 2-bit counter saturates at 3
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 8, 0, 0, 0, 0);
            drive(1, 0, 0, 3, 0, 8, 0, 1);
            drive(1, 0, 0, 3, 0, 8, 0, 1);
        end
        do_reset();

        // randomized traffic over a small register set to provoke hazards
        halt_run = 0;
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 49) == 0), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            halt_run = (cur_mode == 2) ? halt_run + 1 : 0;
            if (halt_run > 4 || $urandom_range(0, 199) == 0) begin
                do_reset();
                halt_run = 0;
            end
        end

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
